// File: rtl/tug_arbiter_if.sv
// rtl/tug_arbiter_if.sv - player/start inputs and rope/winner outputs of the tug-of-war arbiter
interface tug_arbiter_if #(
    parameter int HALF = 3
);
    logic            start;
    logic            push_l;
    logic            push_r;
    logic [2*HALF:0] leds;
    logic            win_l;
    logic            win_r;
    logic            playing;

    modport master (
        output start, push_l, push_r,
        input  leds, win_l, win_r, playing
    );

    modport slave (
        input  start, push_l, push_r,
        output leds, win_l, win_r, playing
    );
endinterface

// File: rtl/tug_arbiter.sv
// rtl/tug_arbiter.sv - tug-of-war pull arbiter with per-player cooldown.
// Optional macro TUG_TIE_ALT_EN: simultaneous pulls alternate between players instead of cancelling.
module tug_arbiter #(
    parameter int HALF = 3,
    parameter int LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    tug_arbiter_if.slave  bus
);
    localparam int NPOS  = 2 * HALF + 1;
    localparam int POS_W = $clog2(NPOS);

    localparam logic [POS_W-1:0] CENTRE      = POS_W'(HALF);
    localparam logic [POS_W-1:0] POS_MAX     = POS_W'(2 * HALF);
    localparam logic [NPOS-1:0]  LEDS_CENTRE = NPOS'(1) << HALF;
    localparam logic [7:0]       LOCK_V      = 8'(LOCK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_WIN_L = 2'd2;
    localparam logic [1:0] S_WIN_R = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [NPOS-1:0] leds_q, leds_d;
    logic            win_l_q, win_r_q, playing_q;
    logic [7:0]      cd_l_q, cd_l_d, cd_r_q, cd_r_d;
    logic            prev_l_q, prev_r_q;

    logic rise_l, rise_r, elig_l, elig_r;
    logic take_l, take_r, load_l, load_r;

`ifdef TUG_TIE_ALT_EN
    logic ptr_q, ptr_d;
    logic tie;
`endif

    always_comb begin
        rise_l = bus.push_l & ~prev_l_q;
        rise_r = bus.push_r & ~prev_r_q;
        elig_l = rise_l && (cd_l_q == 8'd0);
        elig_r = rise_r && (cd_r_q == 8'd0);

`ifdef TUG_TIE_ALT_EN
        // ptr_q == 0 favours left; only the granted player is locked out
        tie    = elig_l & elig_r;
        take_l = elig_l & (~elig_r | ~ptr_q);
        take_r = elig_r & (~elig_l | ptr_q);
        load_l = take_l;
        load_r = take_r;
        ptr_d  = ptr_q ^ (tie && (state_q == S_PLAY) && !bus.start);
`else
        // a tie cancels both moves but still costs both players a cooldown
        take_l = elig_l & ~elig_r;
        take_r = elig_r & ~elig_l;
        load_l = elig_l;
        load_r = elig_r;
`endif

        state_d = state_q;
        pos_d   = pos_q;
        cd_l_d  = 8'd0;
        cd_r_d  = 8'd0;

        case (state_q)
            S_IDLE: begin
                pos_d = CENTRE;
                if (bus.start) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (bus.start) begin
                    pos_d = CENTRE;
                end else begin
                    cd_l_d = load_l ? LOCK_V : ((cd_l_q != 8'd0) ? cd_l_q - 8'd1 : 8'd0);
                    cd_r_d = load_r ? LOCK_V : ((cd_r_q != 8'd0) ? cd_r_q - 8'd1 : 8'd0);
                    if (take_l)      pos_d = pos_q - POS_W'(1);
                    else if (take_r) pos_d = pos_q + POS_W'(1);
                    if (pos_d == '0)          state_d = S_WIN_L;
                    else if (pos_d == POS_MAX) state_d = S_WIN_R;
                end
            end
            S_WIN_L, S_WIN_R: begin
                if (bus.start) begin
                    state_d = S_PLAY;
                    pos_d   = CENTRE;
                end
            end
            default: begin
                state_d = S_IDLE;
                pos_d   = CENTRE;
            end
        endcase

        for (int i = 0; i < NPOS; i++) begin
            leds_d[i] = (pos_d == POS_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pos_q     <= CENTRE;
            leds_q    <= LEDS_CENTRE;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            playing_q <= 1'b0;
            cd_l_q    <= 8'd0;
            cd_r_q    <= 8'd0;
            prev_l_q  <= 1'b0;
            prev_r_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            leds_q    <= leds_d;
            win_l_q   <= (state_d == S_WIN_L);
            win_r_q   <= (state_d == S_WIN_R);
            playing_q <= (state_d == S_PLAY);
            cd_l_q    <= cd_l_d;
            cd_r_q    <= cd_r_d;
            // history tracks buttons in every state so a press held across start is not a pull
            prev_l_q  <= bus.push_l;
            prev_r_q  <= bus.push_r;
        end
    end

`ifdef TUG_TIE_ALT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end
`endif

    assign bus.leds    = leds_q;
    assign bus.win_l   = win_l_q;
    assign bus.win_r   = win_r_q;
    assign bus.playing = playing_q;
endmodule

// File: tb/tb_tug_arbiter.sv
// tb/tb_tug_arbiter.sv - directed vector bench for tug_arbiter (HALF=3, LOCK=4)
module tb_tug_arbiter;
    logic clk;
    logic rst;

    tug_arbiter_if #(.HALF(3)) bus ();

    tug_arbiter #(.HALF(3), .LOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       start;
        logic       pl;
        logic       pr;
        logic [6:0] leds;
        logic       wl;
        logic       wr;
        logic       play;
    } vec_t;

    localparam int NV = 32;
    vec_t vt [NV];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [6:0] leds, input logic wl,
                         input logic wr, input logic play);
        total++;
        if ({bus.leds, bus.win_l, bus.win_r, bus.playing} !== {leds, wl, wr, play}) begin
            bad++;
            $display("FAIL %s: got leds=%b wl=%b wr=%b play=%b, want leds=%b wl=%b wr=%b play=%b",
                     name, bus.leds, bus.win_l, bus.win_r, bus.playing, leds, wl, wr, play);
        end
    endtask

    task automatic step(input logic s, input logic pl, input logic pr);
        bus.start  = s;
        bus.push_l = pl;
        bus.push_r = pr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] tie_leds;
        logic [6:0] exp_leds;
        logic [6:0] one;

`ifdef TUG_TIE_ALT_EN
        tie_leds = 7'b0000100;
`else
        tie_leds = 7'b0001000;
`endif
        one = 7'b0000001;

        //            start pl  pr  leds        wl  wr  play
        vt[0]  = '{1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 7'b0100000, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 7'b1000000, 1'b0, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 7'b1000000, 1'b0, 1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[16] = '{1'b0, 1'b1, 1'b1, tie_leds,   1'b0, 1'b0, 1'b1};
        vt[17] = '{1'b0, 1'b0, 1'b0, tie_leds,   1'b0, 1'b0, 1'b1};
        vt[18] = '{1'b0, 1'b0, 1'b0, tie_leds,   1'b0, 1'b0, 1'b1};
        vt[19] = '{1'b0, 1'b0, 1'b0, tie_leds,   1'b0, 1'b0, 1'b1};
        vt[20] = '{1'b0, 1'b0, 1'b0, tie_leds,   1'b0, 1'b0, 1'b1};
        vt[21] = '{1'b0, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[22] = '{1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[23] = '{1'b1, 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[24] = '{1'b0, 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[25] = '{1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 1'b1};
        vt[26] = '{1'b0, 1'b1, 1'b0, 7'b0000100, 1'b0, 1'b0, 1'b1};
        vt[27] = '{1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 1'b0, 1'b1};
        vt[28] = '{1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 1'b0, 1'b1};
        vt[29] = '{1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 1'b0, 1'b1};
        vt[30] = '{1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 1'b0, 1'b1};
        vt[31] = '{1'b0, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 1'b1};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.push_l = 1'b0;
        bus.push_r = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset", 7'b0001000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vt[i].start, vt[i].pl, vt[i].pr);
            check($sformatf("vec%0d", i), vt[i].leds, vt[i].wl, vt[i].wr, vt[i].play);
        end

        // asynchronous reset mid-game at position 1, checked before the next clock edge
        #1 rst = 1'b0;
        #1 check("async_reset", 7'b0001000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        step(1'b0, 1'b0, 1'b1);
        check("idle_push_r", 7'b0001000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("idle_push_l", 7'b0001000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("restart", 7'b0001000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        check("held_20", 7'b0010000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // four spaced left pulls walk the rope from 4 down to 0
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            exp_leds = one << (3 - k);
            check($sformatf("left_pull%0d", k), exp_leds, (k == 3), 1'b0, (k != 3));
            for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("win_l_frozen", 7'b0000001, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tug_arbiter.md
TUG_ARBITER -- requirements
Module: tug_arbiter

Interface
REQ-001 Parameter HALF, default 3, positions on each side of centre; rope position range 0..2*HALF, centre = HALF.
REQ-002 Parameter LOCK, default 4, cooldown cycles a player is ignored after an accepted pull; legal 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  synchronous game-start/restart request, level sampled each cycle.
REQ-006 push_l  input  1  left player button, already synchronized to clk.
REQ-007 push_r  input  1  right player button, already synchronized to clk.
REQ-008 leds  output  2*HALF+1  one-hot rope position, bit index = position.
REQ-009 win_l / win_r  output  1 each  winner flags, mutually exclusive.
REQ-010 playing  output  1  high only in state PLAY.

Function
REQ-011 States SHALL be IDLE, PLAY, WIN_L, WIN_R; all outputs registered.
REQ-012 Pull event SHALL be rising edge: push_x high this cycle, low the previous cycle; a held button yields exactly one event.
REQ-013 IDLE: pulls ignored, position held at centre; start=1 -> PLAY next cycle.
REQ-014 PLAY: accepted left pull decrements position, accepted right pull increments; leds update on the clock edge that samples the pull (1-cycle latency from push rising).
REQ-015 Pull is accepted only if that player's cooldown counter is 0; acceptance loads counter with LOCK; counter decrements to 0 each cycle; unaccepted pulls are dropped, not queued.
REQ-016 Simultaneous accepted-eligible pulls (same cycle, both cooldowns 0): position unchanged, both cooldowns loaded with LOCK (unless TUG_TIE_ALT_EN).
REQ-017 Position reaching 0 -> WIN_L, reaching 2*HALF -> WIN_R, in the same update; position never leaves 0..2*HALF.
REQ-018 WIN_L/WIN_R: win_l/win_r high, leds frozen at end position, pulls ignored, cooldowns cleared.
REQ-019 start=1 in PLAY, WIN_L or WIN_R: position -> centre, cooldowns -> 0, winners -> 0, state -> PLAY next cycle; start has priority over a pull in the same cycle.
REQ-020 Edge-detect history registers SHALL update in every state, so a button held across start does not produce a pull.

Reset
REQ-021 rst low SHALL immediately force: state IDLE, leds = centre one-hot (bit HALF), win_l=win_r=0, playing=0, cooldowns 0, edge history 0, tie-priority pointer = left.
REQ-022 Reset asserted mid-game SHALL abandon the game with no residual position or cooldown; first rising clock after release evaluates normally.

Configuration
REQ-023 Macro TUG_TIE_ALT_EN: when defined, a simultaneous pull is granted to the player named by a 1-bit priority pointer (reset = left); only the winner moves and gets cooldown LOCK, loser's pull is dropped with no cooldown, pointer toggles after each tie.
REQ-024 Without TUG_TIE_ALT_EN: REQ-016 behaviour; pointer logic absent.

Verification (HALF=3, LOCK=4)
REQ-025 Reset, start pulse, push_r high 1 cycle -> playing=1, leds 0001000 -> 0010000 one cycle after push.
REQ-026 push_r held 20 cycles -> exactly one step; push_r re-pressed 2 cycles after acceptance -> ignored; re-pressed 5 cycles after -> accepted.
REQ-027 Three spaced right pulls -> leds 1000000, win_r=1, playing=0; further pulls no change; start -> leds 0001000, win_r=0, playing=1.
REQ-028 push_l and push_r rise same cycle -> leds unchanged (no macro); with TUG_TIE_ALT_EN first tie moves left, second tie moves right.
REQ-029 rst low asynchronously mid-game at position 1 -> leds 0001000, state IDLE before next clock edge; pulls ignored until start.
REQ-030 start and push_l same cycle -> position centre, no move; push_l held through start yields no pull.
